// File: rtl/ifetch_queue.sv
// ifetch_queue: PC-to-decode fetch front end with a DEPTH-slot in-order response queue,
// credit-based request issue and redirect flush. Define IFQ_MISALIGN_CHECK_EN to add id_misalign_o.
module ifetch_queue #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_i,
  input  logic        redirect_i,
  output logic        pc_stall_o,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o
`ifdef IFQ_MISALIGN_CHECK_EN
  ,
  output logic        id_misalign_o
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]      slotPc_q    [DEPTH];
  logic [31:0]      slotInstr_q [DEPTH];
  logic [DEPTH-1:0] slotFilled_q, slotFilled_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d, dropCnt_q, dropCnt_d;

  logic [CW:0]      inUse;
  logic             credit, misalignPc, canIssue, fire, fakeAlloc, alloc, pop;
  logic [CW-1:0]    unfilledCnt;
  logic [PW-1:0]    fillIdx, idx;
  logic             fillFound, rspDrop, rspWrite, rspConsumed;

`ifdef IFQ_MISALIGN_CHECK_EN
  logic [DEPTH-1:0] slotMis_q;
  assign misalignPc    = (pc_i[1:0] != 2'b00);
  assign id_misalign_o = slotMis_q[head_q];
`else
  assign misalignPc = 1'b0;
`endif

  // Outstanding work includes responses still owed to flushed requests.
  assign inUse    = {1'b0, count_q} + {1'b0, dropCnt_q};
  assign credit   = (inUse < DEPTH_W);
  assign canIssue = rst_ni & ~redirect_i & credit;

  assign imem_req_valid_o = canIssue & ~misalignPc;
  assign imem_req_addr_o  = pc_i;
  assign fire             = imem_req_valid_o & imem_req_ready_i;
  assign fakeAlloc        = canIssue & misalignPc;
  assign alloc            = fire | fakeAlloc;
  assign pc_stall_o       = ~rst_ni | (~redirect_i & ~alloc);

  assign id_valid_o = slotFilled_q[head_q] & (count_q != '0) & ~redirect_i;
  assign id_pc_o    = slotPc_q[head_q];
  assign id_instr_o = slotInstr_q[head_q];
  assign pop        = id_valid_o & id_ready_i;

  // Oldest unfilled slot receives the next response; pre-filled slots may sit in between.
  always_comb begin
    unfilledCnt = '0;
    fillIdx     = head_q;
    fillFound   = 1'b0;
    idx         = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && !slotFilled_q[idx]) begin
        unfilledCnt = unfilledCnt + CW'(1);
        if (!fillFound) begin
          fillIdx   = idx;
          fillFound = 1'b1;
        end
      end
    end
  end

  assign rspDrop     = imem_rsp_valid_i & (dropCnt_q != '0);
  assign rspWrite    = imem_rsp_valid_i & (dropCnt_q == '0) & fillFound & ~redirect_i;
  assign rspConsumed = imem_rsp_valid_i & ((dropCnt_q != '0) | fillFound);

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    dropCnt_d    = dropCnt_q;
    slotFilled_d = slotFilled_q;
    if (redirect_i) begin
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      slotFilled_d = '0;
      dropCnt_d    = dropCnt_q + unfilledCnt - CW'(rspConsumed);
    end else begin
      if (rspDrop) begin
        dropCnt_d = dropCnt_q - CW'(1);
      end
      if (pop) begin
        slotFilled_d[head_q] = 1'b0;
        head_d               = head_q + PW'(1);
      end
      if (alloc) begin
        slotFilled_d[tail_q] = fakeAlloc;
        tail_d               = tail_q + PW'(1);
      end
      if (rspWrite) begin
        slotFilled_d[fillIdx] = 1'b1;
      end
      count_d = count_q + CW'(alloc) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      dropCnt_q    <= '0;
      slotFilled_q <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      dropCnt_q    <= dropCnt_d;
      slotFilled_q <= slotFilled_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        slotPc_q[i]    <= '0;
        slotInstr_q[i] <= '0;
      end
    end else begin
      if (alloc) begin
        slotPc_q[tail_q]    <= pc_i;
        slotInstr_q[tail_q] <= '0;
      end
      if (rspWrite) begin
        slotInstr_q[fillIdx] <= imem_rsp_data_i;
      end
    end
  end

`ifdef IFQ_MISALIGN_CHECK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slotMis_q <= '0;
    end else if (alloc) begin
      slotMis_q[tail_q] <= fakeAlloc;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: queue-level reference model, in-order memory model with random latency,
// directed scenarios with literal expectations, then a randomized run.
module tb_ifetch_queue;
  localparam int DEPTH = 2;
`ifdef IFQ_MISALIGN_CHECK_EN
  localparam bit MisEn = 1'b1;
`else
  localparam bit MisEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] pc;
  logic        redirect;
  logic        pcStall;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] reqAddr;
  logic        rspValid;
  logic [31:0] rspData;
  logic        idValid;
  logic        idReady;
  logic [31:0] idPc;
  logic [31:0] idInstr;
`ifdef IFQ_MISALIGN_CHECK_EN
  logic        idMisalign;
`endif

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .rst_ni          (rstN),
    .pc_i            (pc),
    .redirect_i      (redirect),
    .pc_stall_o      (pcStall),
    .imem_req_valid_o(reqValid),
    .imem_req_ready_i(reqReady),
    .imem_req_addr_o (reqAddr),
    .imem_rsp_valid_i(rspValid),
    .imem_rsp_data_i (rspData),
    .id_valid_o      (idValid),
    .id_ready_i      (idReady),
    .id_pc_o         (idPc),
    .id_instr_o      (idInstr)
`ifdef IFQ_MISALIGN_CHECK_EN
    ,
    .id_misalign_o   (idMisalign)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          filled;
    bit          mis;
  } slot_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  slot_t       slotQ[$];
  memReq_t     memQ[$];
  int          dropCnt;
  int          cyc;
  int          passCnt;
  int          totalCnt;
  logic [31:0] pcReg;
  logic [31:0] redirTarget;
  int          redirAt;
  int unsigned reqReadyPct, idReadyPct, redirPct, latMin, latMax;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
  endtask

  task automatic setMode(input int unsigned lMin, input int unsigned lMax, input int unsigned rdyPct,
                         input int unsigned idPct, input int unsigned rdPct);
    latMin = lMin; latMax = lMax; reqReadyPct = rdyPct; idReadyPct = idPct; redirPct = rdPct;
  endtask

  task automatic applyStimulus();
    pc       = pcReg;
    redirect = 1'b0;
    if (cyc == redirAt) begin
      redirect = 1'b1;
    end else if ($urandom_range(0, 99) < redirPct) begin
      redirect    = 1'b1;
      redirTarget = $urandom & 32'h0003_FFFC;
    end
    reqReady = ($urandom_range(0, 99) < reqReadyPct);
    idReady  = ($urandom_range(0, 99) < idReadyPct);
    if (memQ.size() > 0 && memQ[0].due <= cyc) begin
      rspValid = 1'b1;
      rspData  = memData(memQ[0].addr);
    end else begin
      rspValid = 1'b0;
      rspData  = $urandom;
    end
  endtask

  task automatic advanceModel(input bit fire, input bit misAlloc, input bit pop, input bit stall);
    int unfilled;
    if (redirect) begin
      unfilled = 0;
      foreach (slotQ[i]) if (!slotQ[i].filled) unfilled++;
      dropCnt += unfilled;
      if (rspValid && dropCnt > 0) dropCnt--;
      slotQ.delete();
    end else begin
      if (rspValid) begin
        if (dropCnt > 0) begin
          dropCnt--;
        end else begin
          for (int i = 0; i < slotQ.size(); i++) begin
            if (!slotQ[i].filled) begin
              slotQ[i].instr  = rspData;
              slotQ[i].filled = 1'b1;
              break;
            end
          end
        end
      end
      if (pop) slotQ.delete(0);
      if (fire) slotQ.push_back('{pcReg, 32'h0, 1'b0, 1'b0});
      if (misAlloc) slotQ.push_back('{pcReg, 32'h0, 1'b1, 1'b1});
    end
    if (rspValid) memQ.delete(0);
    if (fire) memQ.push_back('{pcReg, cyc + int'($urandom_range(latMin, latMax))});
    if (redirect) pcReg = redirTarget;
    else if (!stall) pcReg = pcReg + 32'd4;
    cyc++;
  endtask

  task automatic checkOutput();
    bit credit, misPc, expReq, expMis, expFire, expStall, expId;
    credit   = (slotQ.size() + dropCnt) < DEPTH;
    misPc    = MisEn && (pcReg[1:0] != 2'b00);
    expReq   = !redirect && credit && !misPc;
    expMis   = !redirect && credit && misPc;
    expFire  = expReq && reqReady;
    expStall = !redirect && !expFire && !expMis;
    expId    = 1'b0;
    if (slotQ.size() > 0) expId = slotQ[0].filled && !redirect;
    compareVal("model.req_valid", 32'(reqValid), 32'(expReq));
    compareVal("model.pc_stall", 32'(pcStall), 32'(expStall));
    compareVal("model.id_valid", 32'(idValid), 32'(expId));
    if (expReq) compareVal("model.req_addr", reqAddr, pcReg);
    if (expId) begin
      compareVal("model.id_pc", idPc, slotQ[0].pc);
      compareVal("model.id_instr", idInstr, slotQ[0].instr);
`ifdef IFQ_MISALIGN_CHECK_EN
      compareVal("model.id_misalign", 32'(idMisalign), 32'(slotQ[0].mis));
`endif
    end
    advanceModel(expFire, expMis, expId && idReady, expStall);
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      applyStimulus();
      #1;
      checkOutput();
    end
  endtask

  task automatic startReset();
    rstN     = 1'b0;
    redirect = 1'b0;
    reqReady = 1'b0;
    idReady  = 1'b0;
    rspValid = 1'b0;
    rspData  = '0;
    slotQ.delete();
    memQ.delete();
    dropCnt  = 0;
    pcReg    = 32'h0;
    pc       = pcReg;
    redirAt  = -1;
    #1;
    compareVal("reset.req_valid", 32'(reqValid), 32'h0);
    compareVal("reset.pc_stall", 32'(pcStall), 32'h1);
    compareVal("reset.id_valid", 32'(idValid), 32'h0);
    compareVal("reset.id_pc", idPc, 32'h0);
    compareVal("reset.id_instr", idInstr, 32'h0);
  endtask

  task automatic releaseReset();
    repeat (2) @(posedge clk);
    #2 rstN = 1'b1;
    cyc = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    startReset();
    releaseReset();
  endtask

  initial begin
    passCnt = 0; totalCnt = 0; cyc = 0; dropCnt = 0;
    redirTarget = 32'h0; rstN = 1'b0;
    setMode(1, 1, 100, 100, 0);
    doReset();

    // Streaming with single-cycle memory
    runCycles(1);
    compareVal("stream.c0_req_valid", 32'(reqValid), 32'h1);
    compareVal("stream.c0_pc_stall", 32'(pcStall), 32'h0);
    runCycles(2);
    compareVal("stream.c2_id_valid", 32'(idValid), 32'h1);
    compareVal("stream.c2_id_pc", idPc, 32'h0);
    compareVal("stream.c2_id_instr", idInstr, memData(32'h0));
    compareVal("stream.c2_full_stall", 32'(pcStall), 32'h1);
    runCycles(1);
    compareVal("stream.c3_id_pc", idPc, 32'h4);
    runCycles(1);
    compareVal("stream.c4_id_valid", 32'(idValid), 32'h0);
    runCycles(20);

    // Decode back-pressure fills both slots
    doReset();
    setMode(1, 1, 100, 0, 0);
    runCycles(3);
    compareVal("bp.full_req_valid", 32'(reqValid), 32'h0);
    compareVal("bp.full_pc_stall", 32'(pcStall), 32'h1);
    runCycles(2);
    idReadyPct = 100;
    runCycles(1);
    compareVal("bp.first_id_pc", idPc, 32'h0);
    compareVal("bp.first_id_valid", 32'(idValid), 32'h1);
    runCycles(1);
    compareVal("bp.second_id_pc", idPc, 32'h4);
    compareVal("bp.resume_req_valid", 32'(reqValid), 32'h1);
    compareVal("bp.resume_addr", reqAddr, 32'h8);
    runCycles(10);

    // Redirect with two requests in flight, 3-cycle memory
    doReset();
    setMode(3, 3, 100, 100, 0);
    redirAt = 2; redirTarget = 32'h100;
    runCycles(3);
    compareVal("redir.c2_req_valid", 32'(reqValid), 32'h0);
    compareVal("redir.c2_pc_stall", 32'(pcStall), 32'h0);
    runCycles(1);
    compareVal("redir.c3_no_credit", 32'(reqValid), 32'h0);
    runCycles(1);
    compareVal("redir.c4_req_valid", 32'(reqValid), 32'h1);
    compareVal("redir.c4_addr", reqAddr, 32'h100);
    runCycles(4);
    compareVal("redir.c8_id_valid", 32'(idValid), 32'h1);
    compareVal("redir.c8_id_pc", idPc, 32'h100);
    compareVal("redir.c8_id_instr", idInstr, memData(32'h100));
    runCycles(10);

    // Redirect coincident with a response and a would-be pop
    doReset();
    setMode(2, 2, 100, 100, 0);
    redirAt = 3; redirTarget = 32'h200;
    runCycles(4);
    compareVal("redirrsp.c3_id_valid", 32'(idValid), 32'h0);
    runCycles(1);
    compareVal("redirrsp.c4_req_valid", 32'(reqValid), 32'h1);
    compareVal("redirrsp.c4_addr", reqAddr, 32'h200);
    runCycles(3);
    compareVal("redirrsp.c7_id_valid", 32'(idValid), 32'h1);
    compareVal("redirrsp.c7_id_pc", idPc, 32'h200);
    runCycles(6);

    // Asynchronous reset between clock edges
    doReset();
    setMode(1, 1, 100, 100, 0);
    runCycles(4);
    compareVal("areset.pre_id_valid", 32'(idValid), 32'h1);
    compareVal("areset.pre_id_pc", idPc, 32'h4);
    #3;
    startReset();
    releaseReset();
    runCycles(3);
    compareVal("areset.restart_id_valid", 32'(idValid), 32'h1);
    compareVal("areset.restart_id_pc", idPc, 32'h0);
    runCycles(10);

`ifdef IFQ_MISALIGN_CHECK_EN
    // Unaligned PC produces a pre-filled slot instead of a fetch
    doReset();
    setMode(1, 1, 100, 100, 0);
    pcReg = 32'h102;
    runCycles(1);
    compareVal("mis.c0_req_valid", 32'(reqValid), 32'h0);
    compareVal("mis.c0_pc_stall", 32'(pcStall), 32'h0);
    runCycles(1);
    compareVal("mis.c1_id_valid", 32'(idValid), 32'h1);
    compareVal("mis.c1_id_pc", idPc, 32'h102);
    compareVal("mis.c1_id_instr", idInstr, 32'h0);
    compareVal("mis.c1_id_misalign", 32'(idMisalign), 32'h1);
`endif

    // Randomized traffic
    doReset();
    setMode(1, 4, 70, 60, 5);
    runCycles(3000);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
